// File: rtl/sad_pkg.sv
// Shared constants and state encoding for the SAD processor datapath.
package sad_pkg;

   localparam int unsigned IMG_COLS  = 640;
   localparam int unsigned IMG_ROWS  = 480;
   localparam int unsigned X_W       = 10;
   localparam int unsigned Y_W       = 9;
   localparam int unsigned BYTE_BITS = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/row_input_buffer_if.sv
// Byte stream from the UART receiver and row write port towards the image RAM.
interface row_input_buffer_if
   import sad_pkg::*;
#(
   parameter int unsigned COLS   = IMG_COLS,
   parameter int unsigned AW     = Y_W,
   parameter int unsigned BYTE_W = BYTE_BITS
) ();

   logic              byte_valid;
   logic [BYTE_W-1:0] byte_in;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [COLS-1:0]   row_data;

   modport master (
      output byte_valid, byte_in,
      input  wr_en, wr_addr, row_data
   );

   modport slave (
      input  byte_valid, byte_in,
      output wr_en, wr_addr, row_data
   );

endinterface

// File: rtl/row_input_buffer_byte_row_packer.sv
// Packs accepted pixel bytes into one COLS-bit row; byte k lands in columns
// BYTE_W*k .. BYTE_W*k+BYTE_W-1 with the byte MSB as the leftmost pixel.
module byte_row_packer
   import sad_pkg::*;
#(
   parameter int unsigned COLS   = IMG_COLS,
   parameter int unsigned BYTE_W = BYTE_BITS
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_in,
   output logic              row_full,
   output logic [COLS-1:0]   packed_row
);

   localparam int unsigned NBYTES = COLS / BYTE_W;
   localparam int unsigned CW     = $clog2(NBYTES);
   localparam int unsigned LAST   = NBYTES - 1;

   logic [CW-1:0]     byte_cnt;
   logic [COLS-1:0]   shreg;
   logic [BYTE_W-1:0] byte_rev;

   always_comb begin
      byte_rev = '0;
      for (int unsigned j = 0; j < BYTE_W; j++) begin
         byte_rev[j] = byte_in[BYTE_W-1-j];
      end
   end

   // Shifting right and inserting at the top leaves byte 0 in the low columns
   // once a row is complete; stale bits from an abandoned row are fully
   // shifted out by then, so the register never needs clearing.
   assign packed_row = {byte_rev, shreg[COLS-1:BYTE_W]};
   assign row_full   = byte_valid && !clear && (byte_cnt == CW'(LAST));

   always_ff @(posedge clock) begin
      if (!reset) begin
         byte_cnt <= '0;
         shreg    <= '0;
      end else begin
         if (byte_valid) begin
            shreg <= packed_row;
         end
         if (clear) begin
            byte_cnt <= byte_valid ? CW'(1) : '0;
         end else if (byte_valid) begin
            byte_cnt <= row_full ? '0 : byte_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/row_input_buffer.sv
// Input stage of the SAD processor: packs UART pixel bytes into image rows,
// writes each row to the RAM and flags a complete frame.
module row_input_buffer
   import sad_pkg::*;
#(
   parameter int unsigned COLS   = IMG_COLS,
   parameter int unsigned ROWS   = IMG_ROWS,
   parameter int unsigned BYTE_W = BYTE_BITS,
   parameter int unsigned AW     = Y_W
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   row_input_buffer_if.slave    bus,
   output logic [AW:0]          rows_done,
   output logic                 ready,
   output logic                 overrun
);

   state_t          state;
   state_t          state_nxt;
   logic [AW-1:0]   row_cnt;
   logic            accept;
   logic            row_full;
   logic            last_row;
   logic [COLS-1:0] packed_row;

   // start makes the same-cycle byte the first byte of the new frame
   assign accept   = bus.byte_valid && (start || (state == S_FILL));
   assign last_row = (row_cnt == AW'(ROWS - 1));

   byte_row_packer #(
      .COLS   (COLS),
      .BYTE_W (BYTE_W)
   ) u_packer (
      .clock      (clock),
      .reset      (reset),
      .clear      (start),
      .byte_valid (accept),
      .byte_in    (bus.byte_in),
      .row_full   (row_full),
      .packed_row (packed_row)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = S_FILL;
      end else begin
         case (state)
            S_IDLE:  state_nxt = S_IDLE;
            S_FILL:  if (row_full && last_row) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         bus.wr_en    <= 1'b0;
         bus.wr_addr  <= '0;
         bus.row_data <= '0;
         row_cnt      <= '0;
         rows_done    <= '0;
         ready        <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         bus.wr_en <= 1'b0;
         if (start) begin
            row_cnt   <= '0;
            rows_done <= '0;
            ready     <= 1'b0;
            overrun   <= 1'b0;
         end else begin
            if (row_full) begin
               bus.wr_en    <= 1'b1;
               bus.wr_addr  <= row_cnt;
               bus.row_data <= packed_row;
               rows_done    <= rows_done + (AW+1)'(1);
               row_cnt      <= last_row ? '0 : row_cnt + AW'(1);
               if (last_row) begin
                  ready <= 1'b1;
               end
            end
            if (bus.byte_valid && (state != S_FILL)) begin
               overrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_row_input_buffer.sv
// Directed bench for row_input_buffer: a 16x2 instance and a 640x480 instance.
module tb_row_input_buffer;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset;
   logic       s_start;
   logic       b_start;
   logic [1:0] s_rows_done;
   logic       s_ready;
   logic       s_overrun;
   logic [9:0] b_rows_done;
   logic       b_ready;
   logic       b_overrun;

   row_input_buffer_if #(.COLS(16),  .AW(1), .BYTE_W(8)) s_if ();
   row_input_buffer_if #(.COLS(640), .AW(9), .BYTE_W(8)) b_if ();

   row_input_buffer #(.COLS(16), .ROWS(2), .BYTE_W(8), .AW(1)) u_small (
      .clock     (clock),
      .reset     (reset),
      .start     (s_start),
      .bus       (s_if),
      .rows_done (s_rows_done),
      .ready     (s_ready),
      .overrun   (s_overrun)
   );

   row_input_buffer #(.COLS(640), .ROWS(480), .BYTE_W(8), .AW(9)) u_big (
      .clock     (clock),
      .reset     (reset),
      .start     (b_start),
      .bus       (b_if),
      .rows_done (b_rows_done),
      .ready     (b_ready),
      .overrun   (b_overrun)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   function automatic logic [7:0] pat(input int r, input int k);
      return 8'(r * 37 + k * 11 + 5);
   endfunction

   function automatic logic [639:0] exp_row(input int r);
      logic [639:0] v;
      logic [7:0]   b;
      v = '0;
      for (int k = 0; k < 80; k++) begin
         b = pat(r, k);
         for (int j = 0; j < 8; j++) v[8*k+j] = b[7-j];
      end
      return v;
   endfunction

   initial begin
      int   nwr;
      int   early;
      logic prev_wr;

      // 1: reset held with bytes present
      reset = 1'b0; s_start = 1'b0; b_start = 1'b0;
      s_if.byte_valid = 1'b1; s_if.byte_in = 8'h5A;
      b_if.byte_valid = 1'b1; b_if.byte_in = 8'h5A;
      repeat (3) tick();
      chk("rst_wr_en",     b_if.wr_en,    0);
      chk("rst_ready",     b_ready,       0);
      chk("rst_rows_done", b_rows_done,   0);
      chk("rst_overrun",   b_overrun,     0);
      chk("rst_row_data",  b_if.row_data, 0);
      chk("rst_s_overrun", s_overrun,     0);

      // 2: small instance, two rows
      reset = 1'b1; s_if.byte_valid = 1'b0; b_if.byte_valid = 1'b0;
      s_start = 1'b1;
      tick();
      s_start = 1'b0; s_if.byte_valid = 1'b1; s_if.byte_in = 8'hA5;
      tick();
      s_if.byte_in = 8'h3C;
      tick();
      s_if.byte_valid = 1'b0;
      chk("s_wr_en0",     s_if.wr_en,    1);
      chk("s_wr_addr0",   s_if.wr_addr,  0);
      chk("s_row_data0",  s_if.row_data, 16'h3CA5);
      chk("s_rows_done0", s_rows_done,   1);
      chk("s_ready0",     s_ready,       0);
      tick();
      chk("s_wr_en_gap",  s_if.wr_en,    0);
      chk("s_row_hold",   s_if.row_data, 16'h3CA5);
      s_if.byte_valid = 1'b1; s_if.byte_in = 8'h01;
      tick();
      s_if.byte_in = 8'h80;
      tick();
      s_if.byte_valid = 1'b0;
      chk("s_wr_en1",     s_if.wr_en,    1);
      chk("s_wr_addr1",   s_if.wr_addr,  1);
      chk("s_row_data1",  s_if.row_data, 16'h0180);
      chk("s_rows_done1", s_rows_done,   2);
      chk("s_ready1",     s_ready,       1);

      // 3: full 640x480 frame, one byte every cycle
      b_start = 1'b1;
      tick();
      b_start = 1'b0; b_if.byte_valid = 1'b1;
      nwr = 0; prev_wr = 1'b0;
      for (int i = 0; i < 38400; i++) begin
         b_if.byte_in = pat(i / 80, i % 80);
         tick();
         if (b_if.wr_en) begin
            chk("wr_gap",         prev_wr,       0);
            chk("wr_addr",        b_if.wr_addr,  nwr);
            chk("row_data",       b_if.row_data, exp_row(nwr));
            chk("rows_done",      b_rows_done,   nwr + 1);
            chk("ready_at_write", b_ready,       (nwr == 479));
            nwr++;
         end
         prev_wr = b_if.wr_en;
      end
      b_if.byte_valid = 1'b0;
      tick();
      chk("wr_count",        nwr,         480);
      chk("frame_ready",     b_ready,     1);
      chk("frame_rows_done", b_rows_done, 480);
      chk("frame_wr_idle",   b_if.wr_en,  0);

      // 4: byte in DONE, then restart
      b_if.byte_valid = 1'b1; b_if.byte_in = 8'h11;
      tick();
      b_if.byte_valid = 1'b0;
      chk("ovr_set",   b_overrun,  1);
      chk("ovr_no_wr", b_if.wr_en, 0);
      chk("ovr_ready", b_ready,    1);
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      chk("restart_overrun",   b_overrun,   0);
      chk("restart_ready",     b_ready,     0);
      chk("restart_rows_done", b_rows_done, 0);

      // 5: abandon row 3 after 40 bytes, start with byte 0xFF
      b_if.byte_valid = 1'b1;
      for (int i = 0; i < 280; i++) begin
         b_if.byte_in = 8'(i);
         tick();
      end
      b_start = 1'b1; b_if.byte_in = 8'hFF;
      tick();
      b_start = 1'b0;
      chk("mid_rows_done", b_rows_done, 0);
      chk("mid_no_wr",     b_if.wr_en,  0);
      early = 0;
      for (int i = 0; i < 79; i++) begin
         b_if.byte_in = 8'h00;
         tick();
         if (b_if.wr_en && i < 78) early++;
      end
      chk("mid_early_wr",  early,                0);
      chk("mid_wr_en",     b_if.wr_en,           1);
      chk("mid_wr_addr",   b_if.wr_addr,         0);
      chk("mid_row_lo",    b_if.row_data[7:0],   8'hFF);
      chk("mid_row_hi",    b_if.row_data[639:8], 0);
      chk("mid_rows_one",  b_rows_done,          1);

      // 6: reset after 100 rows
      for (int i = 0; i < 99 * 80; i++) begin
         b_if.byte_in = 8'(i * 3);
         tick();
      end
      chk("r100_rows_done", b_rows_done, 100);
      for (int i = 0; i < 10; i++) begin
         b_if.byte_in = 8'h42;
         tick();
      end
      reset = 1'b0; b_if.byte_in = 8'h77;
      tick();
      reset = 1'b1; b_if.byte_valid = 1'b0;
      chk("mrst_wr_en",     b_if.wr_en,    0);
      chk("mrst_wr_addr",   b_if.wr_addr,  0);
      chk("mrst_row_data",  b_if.row_data, 0);
      chk("mrst_rows_done", b_rows_done,   0);
      chk("mrst_ready",     b_ready,       0);
      chk("mrst_overrun",   b_overrun,     0);
      b_if.byte_valid = 1'b1; b_if.byte_in = 8'h33;
      tick();
      b_if.byte_valid = 1'b0;
      chk("idle_overrun", b_overrun,   1);
      chk("idle_no_wr",   b_if.wr_en,  0);
      chk("idle_rows",    b_rows_done, 0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
